// File: rtl/hcsr04_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hcsr04_pkg
//  Description : Shared state encoding and HC-SR04 timing constants for the
//                sensor emulator and the interface that talks to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package hcsr04_pkg;

  // FSM state codes, also shown on db_estado
  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    MEDE_TRIG = 4'd1,
    ESPERA    = 4'd2,
    ECO       = 4'd3,
    HOLDOFF   = 4'd4
  } estado_t;

  // Timing at 50 MHz
  localparam int TRIG_MIN_TICKS = 500;      // 10 us
  localparam int DELAY_TICKS    = 20000;    // 400 us
  localparam int CM_TICKS       = 2941;     // 58.82 us per cm, truncated
  localparam int DIST_MIN       = 2;
  localparam int DIST_MAX       = 400;
  localparam int TIMEOUT_TICKS  = 1900000;  // 38 ms
  localparam int HOLDOFF_TICKS  = 100000;   // 2 ms

  // Width needed to hold 0..m-1 (at least one bit)
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = (a > b) ? a : b;
    return (r > c) ? r : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hcsr04_emulador_contador_m.sv
`default_nettype none
// ============================================================================
//  Module      : contador_m
//  Description : Generic wrap-around counter. Counts 0..ultimo while enabled,
//                asserts fim on the terminal value and wraps to 0 after it.
//                Synchronous clear has priority over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_m #(
  parameter int M = 2,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] ultimo,
  output logic         fim
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  assign fim = (valor_q == ultimo);

  // Next count: clear, hold, step, or wrap at the terminal value
  always_comb begin
    valor_d = valor_q;
    if (clr) begin
      valor_d = '0;
    end else if (en) begin
      valor_d = fim ? '0 : valor_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hcsr04_emulador.sv
`default_nettype none
// ============================================================================
//  Module      : hcsr04_emulador
//  Description : Sensor-side emulation of an HC-SR04. Measures the trigger
//                pulse, waits the fixed delay, then returns an echo whose
//                width encodes the latched distance (or a timeout echo).
//  Revision    : 1.0 - initial release
// ============================================================================
module hcsr04_emulador #(
  parameter int TRIG_MIN_TICKS = hcsr04_pkg::TRIG_MIN_TICKS,
  parameter int DELAY_TICKS    = hcsr04_pkg::DELAY_TICKS,
  parameter int CM_TICKS       = hcsr04_pkg::CM_TICKS,
  parameter int DIST_MIN       = hcsr04_pkg::DIST_MIN,
  parameter int DIST_MAX       = hcsr04_pkg::DIST_MAX,
  parameter int TIMEOUT_TICKS  = hcsr04_pkg::TIMEOUT_TICKS,
  parameter int HOLDOFF_TICKS  = hcsr04_pkg::HOLDOFF_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [3:0] db_estado
);
  import hcsr04_pkg::*;

  localparam int SH_M = max3(DELAY_TICKS, TIMEOUT_TICKS, HOLDOFF_TICKS);
  localparam int SH_W = cnt_width(SH_M);
  localparam int TK_W = cnt_width(CM_TICKS);
  localparam int CM_W = cnt_width(DIST_MAX);
  localparam int TG_W = $clog2(TRIG_MIN_TICKS + 1);

  logic            trig_m_q, trig_s_q;
  estado_t         estado_q, estado_d;
  logic            echo_q, echo_d;
  logic            ocupado_q, ocupado_d;
  logic            armado_q, armado_d;
  logic            tmo_q, tmo_d;
  logic [TG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CM_W-1:0] cm_last_q, cm_last_d;

  logic            cnt_clr, sh_en, tk_en, cm_en;
  logic            sh_fim, tk_fim, cm_fim;
  logic [SH_W-1:0] sh_ultimo;

  // Two-flop synchronizer for the asynchronous trigger
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_m_q <= 1'b0;
      trig_s_q <= 1'b0;
    end else begin
      trig_m_q <= trigger;
      trig_s_q <= trig_m_q;
    end
  end

  // Next-state and output decisions of the measurement FSM
  always_comb begin
    estado_d   = estado_q;
    echo_d     = echo_q;
    ocupado_d  = ocupado_q;
    armado_d   = armado_q;
    tmo_d      = tmo_q;
    trig_cnt_d = trig_cnt_q;
    cm_last_d  = cm_last_q;
    case (estado_q)
      OCIOSO: begin
        // Only a rising trigger is accepted: it must be seen low first
        if (!trig_s_q) begin
          armado_d = 1'b1;
        end else if (armado_q) begin
          estado_d   = MEDE_TRIG;
          trig_cnt_d = '0;
        end
      end
      MEDE_TRIG: begin
        if (trig_s_q) begin
          if (trig_cnt_q != TG_W'(TRIG_MIN_TICKS)) begin
            trig_cnt_d = trig_cnt_q + TG_W'(1);
          end
        end else if (trig_cnt_q >= TG_W'(TRIG_MIN_TICKS)) begin
          estado_d  = ESPERA;
          ocupado_d = 1'b1;
          tmo_d     = (distancia > 9'(DIST_MAX));
          if (distancia < 9'(DIST_MIN)) begin
            cm_last_d = CM_W'(DIST_MIN - 1);
          end else begin
            cm_last_d = CM_W'(distancia - 9'd1);
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      ESPERA: begin
        if (sh_fim) begin
          estado_d = ECO;
          echo_d   = 1'b1;
        end
      end
      ECO: begin
        if (tmo_q ? sh_fim : (tk_fim && cm_fim)) begin
          estado_d = HOLDOFF;
          echo_d   = 1'b0;
        end
      end
      HOLDOFF: begin
        if (sh_fim) begin
          estado_d  = OCIOSO;
          ocupado_d = 1'b0;
          armado_d  = 1'b0;
        end
      end
      default: begin
        estado_d  = OCIOSO;
        echo_d    = 1'b0;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      echo_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      armado_q   <= 1'b0;
      tmo_q      <= 1'b0;
      trig_cnt_q <= '0;
      cm_last_q  <= '0;
    end else begin
      estado_q   <= estado_d;
      echo_q     <= echo_d;
      ocupado_q  <= ocupado_d;
      armado_q   <= armado_d;
      tmo_q      <= tmo_d;
      trig_cnt_q <= trig_cnt_d;
      cm_last_q  <= cm_last_d;
    end
  end

  // Counter control: every state starts its counts from zero
  always_comb begin
    cnt_clr   = (estado_d != estado_q);
    sh_en     = (estado_q == ESPERA) || (estado_q == HOLDOFF) ||
                ((estado_q == ECO) && tmo_q);
    tk_en     = (estado_q == ECO) && !tmo_q;
    cm_en     = tk_en && tk_fim;
    case (estado_q)
      ESPERA:  sh_ultimo = SH_W'(DELAY_TICKS - 1);
      ECO:     sh_ultimo = SH_W'(TIMEOUT_TICKS - 1);
      default: sh_ultimo = SH_W'(HOLDOFF_TICKS - 1);
    endcase
  end

  contador_m #(.M(SH_M), .W(SH_W)) u_cnt_sh (
    .clock (clock), .reset (reset), .clr (cnt_clr), .en (sh_en),
    .ultimo(sh_ultimo), .fim (sh_fim)
  );

  contador_m #(.M(CM_TICKS), .W(TK_W)) u_cnt_tick (
    .clock (clock), .reset (reset), .clr (cnt_clr), .en (tk_en),
    .ultimo(TK_W'(CM_TICKS - 1)), .fim (tk_fim)
  );

  contador_m #(.M(DIST_MAX), .W(CM_W)) u_cnt_cm (
    .clock (clock), .reset (reset), .clr (cnt_clr), .en (cm_en),
    .ultimo(cm_last_q), .fim (cm_fim)
  );

  assign echo      = echo_q;
  assign ocupado   = ocupado_q;
  assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_hcsr04_emulador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hcsr04_emulador
//  Description : Randomized scoreboard bench for the HC-SR04 emulator with
//                shortened timing so every measurement finishes quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hcsr04_emulador;

  localparam int TRIG_MIN = 6;
  localparam int DELAY    = 25;
  localparam int CM       = 5;
  localparam int DMIN     = 2;
  localparam int DMAX     = 400;
  localparam int TIMEOUT  = 2100;
  localparam int HOLDOFF  = 40;
  localparam int BOUND    = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = '0;
  logic       echo, ocupado;
  logic [3:0] db_estado;

  typedef struct {
    int w;
    int fall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  hcsr04_emulador #(
    .TRIG_MIN_TICKS(TRIG_MIN), .DELAY_TICKS(DELAY), .CM_TICKS(CM),
    .DIST_MIN(DMIN), .DIST_MAX(DMAX), .TIMEOUT_TICKS(TIMEOUT),
    .HOLDOFF_TICKS(HOLDOFF)
  ) dut (
    .clock(clk), .reset(rst), .trigger(trigger), .distancia(distancia),
    .echo(echo), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: echo width from the distance rules
  function automatic int model_width(input int d);
    if (d > DMAX) return TIMEOUT;
    if (d < DMIN) return DMIN * CM;
    return d * CM;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got timeout expected event within %0d cycles", nm, BOUND);
  endtask

  // Monitor: measures each echo pulse and compares it against the queue
  bit in_echo = 1'b0;
  int rise_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_echo = 1'b0;
    end else if (echo && !in_echo) begin
      in_echo  = 1'b1;
      rise_cyc = cyc;
    end else if (!echo && in_echo) begin
      in_echo = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_echo got width %0d expected no echo", cyc - rise_cyc);
      end else begin
        exp_t e;
        int   dly;
        e   = exp_q.pop_front();
        chk("echo_width", cyc - rise_cyc, e.w);
        dly = rise_cyc - e.fall;
        checks++;
        if (dly < DELAY + 1 || dly > DELAY + 5) begin
          errors++;
          $display("FAIL echo_delay got %0d expected %0d..%0d", dly, DELAY + 1, DELAY + 5);
        end
      end
    end
  end

  task automatic wait_echo(input bit lvl, input string nm);
    int n = 0;
    while (echo !== lvl && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (echo !== lvl) fail_bound(nm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ocupado == 1'b0 && db_estado == 4'd0) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!(ocupado == 1'b0 && db_estado == 4'd0)) fail_bound("wait_idle");
  endtask

  task automatic pulse(input int tw);
    trigger = 1'b1;
    repeat (tw) @(negedge clk);
    trigger = 1'b0;
  endtask

  // One accepted measurement; mode 1 adds ignored triggers, mode 2 holds
  // trigger high across the end of holdoff
  task automatic measure(input int d, input int mode);
    exp_t e;
    distancia = 9'(d);
    repeat (3) @(negedge clk);
    pulse($urandom_range(TRIG_MIN + 2, TRIG_MIN + 10));
    e.w    = model_width(d);
    e.fall = cyc;
    exp_q.push_back(e);
    repeat (4) @(negedge clk);
    chk("ocupado_set", int'(ocupado), 1);
    chk("estado_espera", int'(db_estado), 2);
    distancia = 9'($urandom_range(0, 511));
    if (mode == 1) begin
      wait_echo(1'b1, "echo_rise");
      pulse(TRIG_MIN + 4);
      wait_echo(1'b0, "echo_fall");
      pulse(TRIG_MIN + 4);
      wait_idle();
    end else if (mode == 2) begin
      wait_echo(1'b1, "echo_rise");
      wait_echo(1'b0, "echo_fall");
      trigger = 1'b1;
      wait_idle();
      repeat (3 * TRIG_MIN) @(negedge clk);
      chk("held_trigger_ignored", int'(db_estado), 0);
      trigger = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      wait_idle();
    end
  endtask

  initial begin
    int dlist[8] = '{5, 0, 1, 401, 511, 390, 2, 400};
    repeat (3) @(negedge clk);
    chk("reset_echo", int'(echo), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_estado", int'(db_estado), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (dlist[i]) measure(dlist[i], (i == 2) ? 1 : 0);

    // Short triggers must be ignored
    for (int k = 0; k < 2; k++) begin
      distancia = 9'(k + 3);
      pulse($urandom_range(1, TRIG_MIN - 2));
      repeat (8) @(negedge clk);
      chk("short_ocupado", int'(ocupado), 0);
      chk("short_estado", int'(db_estado), 0);
    end

    measure(7, 2);
    measure(3, 1);

    // Random distances, mostly short, sometimes in timeout range
    for (int k = 0; k < 8; k++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(401, 511) : $urandom_range(0, 60);
      measure(d, $urandom_range(0, 1));
    end

    // Reset in the middle of an echo
    distancia = 9'd300;
    repeat (3) @(negedge clk);
    pulse(TRIG_MIN + 5);
    wait_echo(1'b1, "echo_rise_rst");
    repeat (50) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_echo", int'(echo), 0);
    chk("midreset_estado", int'(db_estado), 0);
    chk("midreset_ocupado", int'(ocupado), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    measure(9, 0);

    repeat (5) @(negedge clk);
    chk("echoes_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no completion expected finish before 900000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
